pipeline_ctrl_gen: RTL and testbench

Parametrised successor to the CPU's pipeline controller. It turns per-stage stall requests into a thermometer stall mask across NUM_STAGES stages, and turns eret/syscall/break flags into a flush pulse plus a redirect PC. It adds two things the current controller lacks:
- exceptions raised during a global stall (stall_all) are held until the stall releases, instead of being dropped;
- a saturating stall-cycle performance counter.
It sits between the pipeline stages, CP0 and the PC unit.

---
 rtl/pipeline_ctrl_gen_pkg.sv | 29 ++
 rtl/pipeline_ctrl_gen_if.sv | 31 +++
 rtl/pipeline_ctrl_gen_stall_mask_gen.sv | 17 +
 rtl/pipeline_ctrl_gen.sv | 99 +++++++++
 tb/tb_pipeline_ctrl_gen.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_gen_pkg.sv
// Shared definitions for the pipeline controller: default redirect vectors,
// the exception-type encoding, the FSM state encoding and the exception
// priority helper.
package pipeline_ctrl_gen_pkg;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'hbfc0_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'hbfc0_0380;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'd0,
    EXC_ERET    = 2'd1,
    EXC_SYSCALL = 2'd2,
    EXC_BREAK   = 2'd3
  } exc_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // eret outranks syscall, which outranks break.
  function automatic exc_t exc_prio(input logic eret, input logic syscall, input logic brk);
    if (eret)         return EXC_ERET;
    else if (syscall) return EXC_SYSCALL;
    else if (brk)     return EXC_BREAK;
    else              return EXC_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_gen_if.sv
// Bundle of the controller's pipeline/CP0/PC-unit signals.
//   slave  : the controller (consumes requests/flags, drives stall/flush/redirect)
//   master : the pipeline side (drives requests/flags, observes results)
interface pipeline_ctrl_gen_if #(
  parameter int NUM_STAGES = 6,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16
);
  logic [NUM_STAGES-1:0] stall_req;
  logic                  stall_all;
  logic [ADDR_W-1:0]     cp0_epc;
  logic                  eret_flag;
  logic                  syscall_flag;
  logic                  break_flag;
  logic                  perf_clr;
  logic [NUM_STAGES-1:0] stall;
  logic                  flush;
  logic [ADDR_W-1:0]     exc_pc;
  logic                  exc_pending;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output stall_req, stall_all, cp0_epc, eret_flag, syscall_flag, break_flag, perf_clr,
    input  stall, flush, exc_pc, exc_pending, stall_cycles
  );

  modport slave (
    input  stall_req, stall_all, cp0_epc, eret_flag, syscall_flag, break_flag, perf_clr,
    output stall, flush, exc_pc, exc_pending, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl_gen_stall_mask_gen.sv
// Combinational thermometer encoder: a stall request at stage i holds
// stages 0..i, so mask bit i is set when any request at index >= i is set.
//   stall_req : per-stage stall requests
//   mask      : thermometer stall mask, bit 0 = PC
module stall_mask_gen #(
  parameter int NUM_STAGES = 6
) (
  input  logic [NUM_STAGES-1:0] stall_req,
  output logic [NUM_STAGES-1:0] mask
);
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_bit
      assign mask[gi] = |stall_req[NUM_STAGES-1:gi];
    end
  endgenerate
endmodule

// File: rtl/pipeline_ctrl_gen.sv
// Pipeline controller: per-stage stall mask, flush/redirect generation for
// eret/syscall/break, holding of exceptions raised under a global stall, and
// a saturating stall-cycle counter.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : pipeline_ctrl_gen_if.slave (requests/flags in; stall, flush,
//              exc_pc, exc_pending, stall_cycles out)
module pipeline_ctrl_gen
  import pipeline_ctrl_gen_pkg::*;
#(
  parameter int              NUM_STAGES   = 6,
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int              CNT_W        = 16
) (
  input logic              clk,
  input logic              rst,
  pipeline_ctrl_gen_if.slave bus
);

  logic [NUM_STAGES-1:0] req_mask;
  logic [NUM_STAGES-1:0] stall_next;
  logic                  flush_next;
  logic [ADDR_W-1:0]     target_next;
  exc_t                  live_type;

  state_t                state_reg;
  exc_t                  pend_type_reg;
  logic [ADDR_W-1:0]     pend_epc_reg;
  logic [CNT_W-1:0]      cnt_reg;

  stall_mask_gen #(.NUM_STAGES(NUM_STAGES)) u_mask (
    .stall_req (bus.stall_req),
    .mask      (req_mask)
  );

  assign live_type = exc_prio(bus.eret_flag, bus.syscall_flag, bus.break_flag);

  always_comb begin
    flush_next  = 1'b0;
    target_next = EXC_VECTOR;
    stall_next  = '0;
    if (state_reg == ST_PENDING) begin
      // Release fires on the first cycle stall_all is low; live flags ignored.
      flush_next  = !bus.stall_all;
      target_next = (pend_type_reg == EXC_ERET) ? pend_epc_reg : EXC_VECTOR;
    end else begin
      flush_next  = (live_type != EXC_NONE) && !bus.stall_all;
      target_next = (live_type == EXC_ERET) ? bus.cp0_epc : EXC_VECTOR;
    end
    if (rst) flush_next = 1'b0;
    // A flushed pipeline must clear rather than hold.
    if (!rst && !flush_next) stall_next = bus.stall_all ? '1 : req_mask;
  end

  assign bus.stall        = stall_next;
  assign bus.flush        = flush_next;
  assign bus.exc_pc       = flush_next ? target_next : RESET_VECTOR;
  assign bus.exc_pending  = (state_reg == ST_PENDING) && !rst;
  assign bus.stall_cycles = cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pend_type_reg <= EXC_NONE;
      pend_epc_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (live_type != EXC_NONE && bus.stall_all) begin
            state_reg     <= ST_PENDING;
            pend_type_reg <= live_type;
            pend_epc_reg  <= (live_type == EXC_ERET) ? bus.cp0_epc : '0;
          end
        end
        ST_PENDING: begin
          // First exception wins: nothing new is latched while pending.
          if (!bus.stall_all) begin
            state_reg     <= ST_IDLE;
            pend_type_reg <= EXC_NONE;
            pend_epc_reg  <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (bus.perf_clr) begin
      cnt_reg <= '0;
    end else if (stall_next[0] && cnt_reg != '1) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl_gen.sv
module tb_pipeline_ctrl_gen;
  localparam logic [31:0] RV  = 32'hbfc0_0000;
  localparam logic [31:0] EXC = 32'hbfc0_0380;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0]  stall_req = '0;
  logic        stall_all = 1'b0;
  logic [31:0] cp0_epc = '0;
  logic        eret_flag = 1'b0, syscall_flag = 1'b0, break_flag = 1'b0, perf_clr = 1'b0;

  always #5 clk = ~clk;

  pipeline_ctrl_gen_if #(.NUM_STAGES(6), .ADDR_W(32), .CNT_W(16)) bus16 ();
  pipeline_ctrl_gen_if #(.NUM_STAGES(6), .ADDR_W(32), .CNT_W(4))  bus4 ();

  assign bus16.stall_req = stall_req;    assign bus4.stall_req = stall_req;
  assign bus16.stall_all = stall_all;    assign bus4.stall_all = stall_all;
  assign bus16.cp0_epc = cp0_epc;        assign bus4.cp0_epc = cp0_epc;
  assign bus16.eret_flag = eret_flag;    assign bus4.eret_flag = eret_flag;
  assign bus16.syscall_flag = syscall_flag; assign bus4.syscall_flag = syscall_flag;
  assign bus16.break_flag = break_flag;  assign bus4.break_flag = break_flag;
  assign bus16.perf_clr = perf_clr;      assign bus4.perf_clr = perf_clr;

  pipeline_ctrl_gen #(.NUM_STAGES(6), .ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus16.slave));
  pipeline_ctrl_gen #(.NUM_STAGES(6), .ADDR_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: a latched exception (if any) and both counters.
  bit          m_pend = 0;
  int          m_ptype = 0;   // 1 eret, 2 syscall, 3 break
  logic [31:0] m_pepc = '0;
  int          m_cnt16 = 0;
  int          m_cnt4 = 0;
  logic [5:0]  e_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: predict combinational outputs from the rules and compare.
  task automatic sample();
    int lt, k;
    logic e_flush, e_pend;
    logic [31:0] tgt, e_pc;
    @(negedge clk);
    if (rst) begin m_pend = 0; m_ptype = 0; m_cnt16 = 0; m_cnt4 = 0; end
    lt = eret_flag ? 1 : syscall_flag ? 2 : break_flag ? 3 : 0;
    k = -1;
    for (int i = 0; i < 6; i++) if (stall_req[i]) k = i;
    if (rst) begin
      e_flush = 0; e_stall = '0; e_pc = RV; e_pend = 0;
    end else begin
      e_flush = m_pend ? !stall_all : (lt != 0 && !stall_all);
      tgt = m_pend ? ((m_ptype == 1) ? m_pepc : EXC) : ((lt == 1) ? cp0_epc : EXC);
      if (e_flush) e_stall = '0;
      else if (stall_all) e_stall = 6'h3f;
      else e_stall = 6'((1 << (k + 1)) - 1);
      e_pc = e_flush ? tgt : RV;
      e_pend = m_pend;
    end
    chk("stall", 32'(bus16.stall), 32'(e_stall));
    chk("flush", 32'(bus16.flush), 32'(e_flush));
    chk("exc_pc", bus16.exc_pc, e_pc);
    chk("exc_pending", 32'(bus16.exc_pending), 32'(e_pend));
    chk("cycles16", 32'(bus16.stall_cycles), 32'(m_cnt16));
    chk("cycles4", 32'(bus4.stall_cycles), 32'(m_cnt4));
    $display("vec t=%0t req=%b all=%b e/s/b=%b%b%b stall=%b flush=%b pc=%h pend=%b cnt=%0d/%0d",
             $time, stall_req, stall_all, eret_flag, syscall_flag, break_flag,
             bus16.stall, bus16.flush, bus16.exc_pc, bus16.exc_pending,
             bus16.stall_cycles, bus4.stall_cycles);
  endtask

  task automatic tick();
    int lt;
    @(posedge clk);
    lt = eret_flag ? 1 : syscall_flag ? 2 : break_flag ? 3 : 0;
    if (rst) begin
      m_pend = 0; m_cnt16 = 0; m_cnt4 = 0;
    end else begin
      if (perf_clr) begin m_cnt16 = 0; m_cnt4 = 0; end
      else if (e_stall[0]) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (m_pend) begin
        if (!stall_all) m_pend = 0;
      end else if (lt != 0 && stall_all) begin
        m_pend = 1; m_ptype = lt; m_pepc = cp0_epc;
      end
    end
    #1;
  endtask

  task automatic quiet();
    stall_req = '0; stall_all = 0; eret_flag = 0; syscall_flag = 0;
    break_flag = 0; perf_clr = 0;
  endtask

  initial begin
    int c0;
    // Reset: outputs forced.
    sample(); tick();
    rst = 0;
    sample(); tick();

    // 1: thermometer stall mask and counting.
    c0 = m_cnt16;
    stall_req = 6'b000100; sample(); chk("t1_a", 32'(bus16.stall), 32'h07); tick();
    stall_req = 6'b001100; sample(); chk("t1_b", 32'(bus16.stall), 32'h0f); tick();
    stall_req = 6'b000000; sample(); chk("t1_c", 32'(bus16.stall), 32'h00);
    chk("t1_cnt", 32'(bus16.stall_cycles), 32'(c0 + 2)); tick();

    // 2: immediate syscall flush.
    syscall_flag = 1; stall_req = 6'b000011; sample();
    chk("t2_flush", 32'(bus16.flush), 32'd1); chk("t2_pc", bus16.exc_pc, EXC); tick();
    quiet(); sample(); chk("t2_idle_pc", bus16.exc_pc, RV); tick();

    // 3: eret under stall_all, EPC captured on the first cycle.
    stall_all = 1; eret_flag = 1; cp0_epc = 32'h8000_1234; sample(); tick();
    eret_flag = 0; cp0_epc = 32'h1111_0000; sample(); tick();
    cp0_epc = 32'h2222_0000; sample(); tick();
    stall_all = 0; sample();
    chk("t3_flush", 32'(bus16.flush), 32'd1); chk("t3_pc", bus16.exc_pc, 32'h8000_1234); tick();
    sample(); tick();

    // 4: first exception wins while pending; live flags ignored on release.
    stall_all = 1; break_flag = 1; sample(); tick();
    break_flag = 0; eret_flag = 1; cp0_epc = 32'h4444_0000; sample(); tick();
    eret_flag = 0; stall_all = 0; syscall_flag = 1; sample();
    chk("t4_pc", bus16.exc_pc, EXC); tick();
    syscall_flag = 0; sample(); chk("t4_once", 32'(bus16.flush), 32'd0); tick();

    // 5: eret beats syscall.
    eret_flag = 1; syscall_flag = 1; cp0_epc = 32'h8000_0040; sample();
    chk("t5_pc", bus16.exc_pc, 32'h8000_0040); tick();
    quiet();

    // 6a: saturation of the 4-bit counter, then clear.
    stall_req = 6'b100000;
    for (int i = 0; i < 20; i++) begin sample(); tick(); end
    sample(); chk("t6_sat", 32'(bus4.stall_cycles), 32'd15); tick();
    perf_clr = 1; sample(); tick();
    quiet(); sample(); chk("t6_clr", 32'(bus4.stall_cycles), 32'd0); tick();

    // 6b: asynchronous reset while pending.
    stall_all = 1; break_flag = 1; sample(); tick();
    break_flag = 0; sample(); tick();
    rst = 1; #1;
    chk("t6_rst_pend", 32'(bus16.exc_pending), 32'd0);
    sample(); tick();
    rst = 0; stall_all = 0; sample(); chk("t6_noflush", 32'(bus16.flush), 32'd0); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      stall_req    = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      stall_all    = ($urandom_range(0, 9) < 3);
      eret_flag    = ($urandom_range(0, 9) == 0);
      syscall_flag = ($urandom_range(0, 9) == 0);
      break_flag   = ($urandom_range(0, 9) == 0);
      perf_clr     = ($urandom_range(0, 29) == 0);
      cp0_epc      = $urandom;
      sample(); tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
